// File: rtl/corr_search_ctrl.sv
// Position-search controller: on each frame-done edge, rasters a candidate point over a
// full or tracking window, requests one correlation per point, and reports the best one.
module corr_search_ctrl #(
  parameter int COORD_W     = 13,
  parameter int CORR_W      = 24,
  parameter int X_START     = 0,
  parameter int X_END       = 639,
  parameter int Y_START     = 0,
  parameter int Y_END       = 479,
  parameter int STEP        = 1,
  parameter int RADIUS      = 16,
  parameter bit MAX_MODE    = 1'b1,
  parameter int LOCK_THRESH = 0
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iFrameDone,
  input  logic               iTrackEn,
  output logic               oCorrReq,
  input  logic               iCorrFinished,
  input  logic [CORR_W-1:0]  iCurrentCorr,
  output logic [COORD_W-1:0] oX,
  output logic [COORD_W-1:0] oY,
  output logic [COORD_W-1:0] oXresult,
  output logic [COORD_W-1:0] oYresult,
  output logic [CORR_W-1:0]  oResultCorr,
  output logic               oLocked,
  output logic               oBusy,
  output logic               oStatusLed,
  output logic               oFinished
);
  localparam int EW = COORD_W + 1;
  typedef logic [EW-1:0] ext_t;
  localparam ext_t XS  = ext_t'(X_START);
  localparam ext_t XE  = ext_t'(X_END);
  localparam ext_t YS  = ext_t'(Y_START);
  localparam ext_t YE  = ext_t'(Y_END);
  localparam ext_t STP = ext_t'(STEP);
  localparam ext_t RAD = ext_t'(RADIUS);
  localparam logic [CORR_W-1:0] THR = CORR_W'(LOCK_THRESH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t              state;
  logic                fd_prev, cf_prev;
  ext_t                x0, x1, y0, y1;
  logic [COORD_W-1:0]  best_x, best_y;
  logic [CORR_W-1:0]   best_corr;
  logic                best_valid;

  logic                fd_edge, cf_edge, track;
  ext_t                rx, ry, wx0, wx1, wy0, wy1, nx, ny;
  logic                row_end, scan_end, take, meets;
  logic [COORD_W-1:0]  nb_x, nb_y;
  logic [CORR_W-1:0]   nb_corr;

  always_comb begin
    fd_edge  = iFrameDone & ~fd_prev;
    cf_edge  = iCorrFinished & ~cf_prev;
    track    = iTrackEn & oLocked;
    rx       = {1'b0, oXresult};
    ry       = {1'b0, oYresult};
    // Clamp the tracking window; the compare form avoids underflow at the low edge.
    wx0      = track ? ((rx < XS + RAD) ? XS : rx - RAD) : XS;
    wx1      = track ? ((rx + RAD > XE) ? XE : rx + RAD) : XE;
    wy0      = track ? ((ry < YS + RAD) ? YS : ry - RAD) : YS;
    wy1      = track ? ((ry + RAD > YE) ? YE : ry + RAD) : YE;
    nx       = {1'b0, oX} + STP;
    ny       = {1'b0, oY} + STP;
    row_end  = nx > x1;
    scan_end = ny > y1;
    // Strict comparison so that on ties the earliest point in raster order is kept.
    take     = !best_valid ||
               (MAX_MODE ? (iCurrentCorr > best_corr) : (iCurrentCorr < best_corr));
    nb_corr  = take ? iCurrentCorr : best_corr;
    nb_x     = take ? oX : best_x;
    nb_y     = take ? oY : best_y;
    meets    = MAX_MODE ? (nb_corr >= THR) : (nb_corr <= THR);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= IDLE;
      fd_prev     <= 1'b0;
      cf_prev     <= 1'b0;
      x0          <= XS;
      x1          <= XE;
      y0          <= YS;
      y1          <= YE;
      oX          <= COORD_W'(X_START);
      oY          <= COORD_W'(Y_START);
      best_x      <= '0;
      best_y      <= '0;
      best_corr   <= '0;
      best_valid  <= 1'b0;
      oXresult    <= '0;
      oYresult    <= '0;
      oResultCorr <= '0;
      oLocked     <= 1'b0;
      oBusy       <= 1'b0;
      oCorrReq    <= 1'b0;
      oFinished   <= 1'b0;
      oStatusLed  <= 1'b0;
    end else begin
      fd_prev   <= iFrameDone;
      cf_prev   <= iCorrFinished;
      oCorrReq  <= 1'b0;
      oFinished <= 1'b0;
      case (state)
        IDLE: if (fd_edge) begin
          x0         <= wx0;
          x1         <= wx1;
          y0         <= wy0;
          y1         <= wy1;
          oX         <= COORD_W'(wx0);
          oY         <= COORD_W'(wy0);
          best_valid <= 1'b0;
          oCorrReq   <= 1'b1;
          oBusy      <= 1'b1;
          state      <= REQ;
        end
        REQ: state <= WAIT;
        WAIT: if (cf_edge) begin
          best_corr  <= nb_corr;
          best_x     <= nb_x;
          best_y     <= nb_y;
          best_valid <= 1'b1;
          if (!row_end) begin
            oX       <= COORD_W'(nx);
            oCorrReq <= 1'b1;
            state    <= REQ;
          end else begin
            oX <= COORD_W'(x0);
            if (scan_end) begin
              // Results are published on the same edge that raises oFinished.
              oXresult    <= nb_x;
              oYresult    <= nb_y;
              oResultCorr <= nb_corr;
              oLocked     <= meets;
              oStatusLed  <= ~oStatusLed;
              oFinished   <= 1'b1;
              state       <= DONE;
            end else begin
              oY       <= COORD_W'(ny);
              oCorrReq <= 1'b1;
              state    <= REQ;
            end
          end
        end
        DONE: begin
          oBusy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_corr_search_ctrl.sv
// Scoreboard bench: expected raster points and scan results are queued at frame start
// and popped as the controller issues requests and completes scans.
module tb_corr_search_ctrl;
  localparam int CW = 13;
  localparam int SW = 24;

  logic          gclk = 1'b0;
  logic          iRST_N, iFrameDone, iTrackEn, iCorrFinished;
  logic [SW-1:0] iCurrentCorr;
  logic          oCorrReq, oLocked, oBusy, oStatusLed, oFinished;
  logic [CW-1:0] oX, oY, oXresult, oYresult;
  logic [SW-1:0] oResultCorr;

  always #5 gclk = ~gclk;

  corr_search_ctrl #(
    .COORD_W(CW), .CORR_W(SW), .X_START(0), .X_END(3), .Y_START(0), .Y_END(2),
    .STEP(1), .RADIUS(1), .MAX_MODE(1'b1), .LOCK_THRESH(50)
  ) dut (
    .iCLK(gclk), .iRST_N(iRST_N), .iFrameDone(iFrameDone), .iTrackEn(iTrackEn),
    .oCorrReq(oCorrReq), .iCorrFinished(iCorrFinished), .iCurrentCorr(iCurrentCorr),
    .oX(oX), .oY(oY), .oXresult(oXresult), .oYresult(oYresult),
    .oResultCorr(oResultCorr), .oLocked(oLocked), .oBusy(oBusy),
    .oStatusLed(oStatusLed), .oFinished(oFinished)
  );

  typedef struct { int x; int y; int c; bit lk; } res_t;

  int   score_map [4][3];
  int   qx[$], qy[$];
  res_t rq[$];
  int   total = 0, bad = 0;
  bit   exp_led = 1'b0;
  bit   mdl_lock = 1'b0;
  int   mdl_x = 0, mdl_y = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic fill(input int v);
    for (int x = 0; x < 4; x++) for (int y = 0; y < 3; y++) score_map[x][y] = v;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_x"},    32'(oX), 0);
    chk({tag, "_y"},    32'(oY), 0);
    chk({tag, "_xr"},   32'(oXresult), 0);
    chk({tag, "_yr"},   32'(oYresult), 0);
    chk({tag, "_corr"}, 32'(oResultCorr), 0);
    chk({tag, "_lock"}, 32'(oLocked), 0);
    chk({tag, "_busy"}, 32'(oBusy), 0);
    chk({tag, "_req"},  32'(oCorrReq), 0);
    chk({tag, "_fin"},  32'(oFinished), 0);
    chk({tag, "_led"},  32'(oStatusLed), 0);
  endtask

  // spur: frame edge during the first WAIT and iCorrFinished held across the second request.
  // abort_at: point index at which reset is asserted (-1 = none).
  task automatic scan(input bit trk, input bit spur, input int abort_at);
    int x0, x1, y0, y1, ex, ey, idx;
    bit bv;
    res_t r;
    if (trk && mdl_lock) begin
      x0 = (mdl_x - 1 < 0) ? 0 : mdl_x - 1;  x1 = (mdl_x + 1 > 3) ? 3 : mdl_x + 1;
      y0 = (mdl_y - 1 < 0) ? 0 : mdl_y - 1;  y1 = (mdl_y + 1 > 2) ? 2 : mdl_y + 1;
    end else begin
      x0 = 0; x1 = 3; y0 = 0; y1 = 2;
    end
    bv = 1'b0; r.x = 0; r.y = 0; r.c = 0;
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) begin
        qx.push_back(x); qy.push_back(y);
        if (!bv || score_map[x][y] > r.c) begin r.x = x; r.y = y; r.c = score_map[x][y]; bv = 1'b1; end
      end
    r.lk = (r.c >= 50);
    rq.push_back(r);

    @(negedge gclk); iTrackEn = trk; iFrameDone = 1'b1;
    @(negedge gclk); iFrameDone = 1'b0;
    chk("busy_start", 32'(oBusy), 1);
    idx = 0;
    while (qx.size() > 0) begin
      ex = qx.pop_front(); ey = qy.pop_front();
      chk("req", 32'(oCorrReq), 1);
      chk("req_x", 32'(oX), ex);
      chk("req_y", 32'(oY), ey);
      @(negedge gclk);
      chk("req_pulse", 32'(oCorrReq), 0);
      chk("busy", 32'(oBusy), 1);
      if (idx == abort_at) begin
        iRST_N = 1'b0;
        #1 chk_reset("abort");
        qx.delete(); qy.delete(); void'(rq.pop_back());
        mdl_lock = 1'b0; mdl_x = 0; mdl_y = 0; exp_led = 1'b0;
        @(negedge gclk); iRST_N = 1'b1;
        return;
      end
      if (spur && idx == 0) iFrameDone = 1'b1;
      @(negedge gclk); iFrameDone = 1'b0;
      chk("x_stable", 32'(oX), ex);
      if (spur && idx == 1) begin
        repeat (3) begin
          @(negedge gclk);
          chk("hold_noreq", 32'(oCorrReq), 0);
          chk("hold_nofin", 32'(oFinished), 0);
          chk("hold_x", 32'(oX), ex);
        end
        iCorrFinished = 1'b0;
        @(negedge gclk);
      end
      iCurrentCorr = SW'(score_map[ex][ey]); iCorrFinished = 1'b1;
      @(negedge gclk);
      if (!(spur && idx == 0)) iCorrFinished = 1'b0;
      idx++;
    end
    r = rq.pop_front();
    exp_led = ~exp_led;
    chk("fin", 32'(oFinished), 1);
    chk("fin_noreq", 32'(oCorrReq), 0);
    chk("busy_done", 32'(oBusy), 1);
    chk("xres", 32'(oXresult), r.x);
    chk("yres", 32'(oYresult), r.y);
    chk("corr", 32'(oResultCorr), r.c);
    chk("lock", 32'(oLocked), 32'(r.lk));
    chk("led", 32'(oStatusLed), 32'(exp_led));
    mdl_x = r.x; mdl_y = r.y; mdl_lock = r.lk;
    @(negedge gclk);
    chk("fin_pulse", 32'(oFinished), 0);
    chk("busy_end", 32'(oBusy), 0);
    chk("xres_hold", 32'(oXresult), r.x);
  endtask

  initial begin
    iRST_N = 1'b0; iFrameDone = 1'b0; iTrackEn = 1'b0; iCorrFinished = 1'b0; iCurrentCorr = '0;
    repeat (3) @(negedge gclk);
    chk_reset("rst");
    iRST_N = 1'b1;
    @(negedge gclk);

    fill(10); score_map[2][1] = 100;                       scan(1'b0, 1'b0, -1); // full
    fill(10); score_map[1][0] = 80; score_map[3][2] = 80;  scan(1'b0, 1'b0, -1); // tie
    fill(10); score_map[3][2] = 100;                       scan(1'b0, 1'b0, -1); // lock corner
    fill(10); score_map[2][2] = 90;                        scan(1'b1, 1'b0, -1); // 2x2 track
    fill(20);                                              scan(1'b1, 1'b0, -1); // lock loss
    fill(10); score_map[0][0] = 60;                        scan(1'b1, 1'b0, -1); // back to full
    fill(10); score_map[3][1] = 70;                        scan(1'b0, 1'b1, -1); // spurious
    fill(10);                                              scan(1'b0, 1'b0, 4);  // reset mid-scan
    fill(10); score_map[1][2] = 55;                        scan(1'b1, 1'b0, -1); // full after reset
    repeat (3) begin
      @(negedge gclk);
      chk("idle_fin", 32'(oFinished), 0);
      chk("idle_req", 32'(oCorrReq), 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/corr_search_ctrl.md
# corr_search_ctrl

Parametrised position-search controller for the camera correlation path. It replaces the fixed full-frame X/Y scanner. On each frame-done event it steps a candidate coordinate over a search window and requests one correlation per point. It keeps the best score and reports the winning position. A tracking mode restricts later scans to a clamped window around the last locked position, and a threshold decides whether lock is kept.

## Interface
- COORD_W, 13, coordinate width
- CORR_W, 24, correlation score width (unsigned)
- X_START, 0, first X position of full scan
- X_END, 639, last X position (inclusive)
- Y_START, 0, first Y position of full scan
- Y_END, 479, last Y position (inclusive)
- STEP, 1, coordinate increment (≥1)
- RADIUS, 16, tracking half-window in pixels
- MAX_MODE, 1, 1 = larger score is better; 0 = smaller is better (SAD)
- LOCK_THRESH, 0, score a scan's best must meet (≥ if MAX_MODE=1, ≤ if 0) to set lock

Ports (one clock; reset is asynchronous and active-low):
- iCLK  in  1  clock
- iRST_N  in  1  asynchronous active-low reset
- iFrameDone  in  1  frame complete; rising edge starts a scan
- iTrackEn  in  1  tracking mode request, sampled at scan start
- oCorrReq  out  1  one-cycle request to compute correlation at (oX,oY)
- iCorrFinished  in  1  correlator done; rising edge accepted in WAIT only
- iCurrentCorr  in  CORR_W  score, valid on the iCorrFinished rising edge
- oX, oY  out  COORD_W  current candidate position
- oXresult, oYresult  out  COORD_W  best position of the last completed scan
- oResultCorr  out  CORR_W  best score of the last completed scan
- oLocked  out  1  last scan met LOCK_THRESH
- oBusy  out  1  scan in progress
- oStatusLed  out  1  toggles on each completed scan
- oFinished  out  1  one-cycle scan-complete pulse

## Operation
- Edge detection: registered previous values of iFrameDone and iCorrFinished. edge = now & ~prev.
- State IDLE: oBusy=0. On an iFrameDone edge, latch the window and go to REQ.
  - Window when iTrackEn=1 and oLocked=1: x0=max(X_START, oXresult−RADIUS), x1=min(X_END, oXresult+RADIUS); y0/y1 the same around oYresult. Arithmetic is in COORD_W+1 bits with no underflow or overflow.
  - Window otherwise: full X_START..X_END × Y_START..Y_END.
  - On entry: oX=x0, oY=y0, best_valid=0.
- State REQ: oCorrReq=1 for exactly this cycle, then go to WAIT.
- State WAIT: on an iCorrFinished edge:
  - If best_valid=0 or the score is strictly better, store score, oX and oY as best and set best_valid.
  - Advance raster: if oX+STEP>x1 then oX=x0 and the row advances; otherwise oX+=STEP. When the row advances and oY+STEP>y1, go to DONE; otherwise oY+=STEP and go to REQ.
- State DONE, one cycle:
  - oFinished=1; oXresult, oYresult and oResultCorr take the best values.
  - oLocked = best meets LOCK_THRESH; oStatusLed toggles.
  - Go to IDLE.
- Ties: the first point visited wins.
- Ignored edges: iFrameDone edges outside IDLE. iCorrFinished edges outside WAIT (the prev register still updates).
- Scan order: row-major, X fastest.

## Timing
- Reset values:
  - oX=X_START, oY=Y_START.
  - oXresult=oYresult=0, oResultCorr=0.
  - oLocked=0, oBusy=0, oCorrReq=0, oFinished=0, oStatusLed=0.
  - State IDLE, edge registers 0.
- Reset takes effect immediately at any time, including mid-scan. The scan in progress is abandoned and no oFinished is produced.
- An iFrameDone edge sampled at clock edge N gives oCorrReq=1 and oBusy=1 during cycle N+1.
- An iCorrFinished edge sampled at edge M gives the next oCorrReq during cycle M+1. On the last point, oFinished is 1 during cycle M+1 instead.
- oX and oY are stable from the cycle oCorrReq is high until the accepting edge.
- Result outputs update together with oFinished and hold until the next DONE.
- oBusy is 1 from REQ through DONE inclusive.
- Holding iFrameDone high never retriggers a scan. Holding iCorrFinished high never completes more than one point.
- Point count: ((x1−x0)/STEP+1)·((y1−y0)/STEP+1), integer division.

## Test plan
Bench parameters: X 0..3, Y 0..2, STEP=1, RADIUS=1, MAX_MODE=1, LOCK_THRESH=50.
1. Full scan: iTrackEn=0, frame edge; correlator answers score 100 at (2,1) and 10 elsewhere → exactly 12 oCorrReq pulses in raster order, then one oFinished pulse with oXresult=2, oYresult=1, oResultCorr=100, oLocked=1, oStatusLed=1.
2. Tie: score 80 at (1,0) and (3,2), 10 elsewhere → oXresult=1, oYresult=0.
3. Tracking: lock at (3,2), then iTrackEn=1 and a frame edge → window x 2..3, y 1..2; 4 requests at (2,1), (3,1), (2,2), (3,2).
4. Lock loss: tracking scan with all scores 20 → oLocked=0, oResultCorr=20; the next frame with iTrackEn=1 runs the full 12 points.
5. Spurious edges: an iFrameDone edge during WAIT and iCorrFinished held high across two requests → no restart; the second point waits for a fresh iCorrFinished edge.
6. Reset mid-scan: assert iRST_N=0 at point 5 → all outputs return to reset values at once; the next frame edge starts a full scan with no oFinished for the aborted scan.
